// File: rtl/uart_frame_rx.sv
// 8N1 UART frame receiver with 16x oversampling, 3-sample majority voting,
// framing-error detection with break suppression, and idle/end-of-packet
// detection. The tick generator is free-running and never re-phased by rx.
module uart_frame_rx #(
    parameter int BAUD_DIV   = 27,
    parameter int IDLE_TICKS = 160
) (
    input  logic       clk_fast,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       framing_err,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [BW-1:0] r_baud_cnt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_samp_cnt;
    logic          r_s7;
    logic          r_s8;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_armed;
    logic [IW-1:0] r_idle_cnt;
    logic [IW-1:0] w_idle_nxt;
    logic          r_pending;
    logic [7:0]    r_data;
    logic          r_ready;
    logic          r_ferr;
    logic          r_idle;
    logic          r_eop;

    logic w_tick;
    logic w_at9;
    logic w_at15;
    logic w_bit;
    logic w_good_stop;
    logic w_bad_stop;
    logic w_eop_fire;

    assign w_tick      = (r_baud_cnt == BAUD_LAST);
    assign w_at9       = w_tick && (r_samp_cnt == 4'd9);
    assign w_at15      = w_tick && (r_samp_cnt == 4'd15);
    assign w_bit       = maj3(r_s7, r_s8, r_rx_sync);
    assign w_good_stop = (r_state == ST_STOP) && w_at9 && w_bit;
    assign w_bad_stop  = (r_state == ST_STOP) && w_at9 && !w_bit;
    assign w_eop_fire  = r_pending && (w_idle_nxt == IDLE_MAX) && (r_idle_cnt != IDLE_MAX);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
        end
    end

    // Frame state register.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: STOP exits at count 9 so a start edge in the
    // second half of the stop bit is not missed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rx_sync && r_armed) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_at9 && w_bit) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_at15) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_at15 && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_at9) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-bit sample counter, mid-bit samples, bit index and shift register.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_samp_cnt <= 4'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (r_state == ST_IDLE) begin
                r_samp_cnt <= 4'd0;
            end else if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end
            if (w_tick && (r_samp_cnt == 4'd7)) begin
                r_s7 <= r_rx_sync;
            end
            if (w_tick && (r_samp_cnt == 4'd8)) begin
                r_s8 <= r_rx_sync;
            end
            if (r_state == ST_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_at15) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if ((r_state == ST_DATA) && w_at9) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end
        end
    end

    // Armed flag: a framing error disarms until the line is seen high,
    // so a held-low break cannot retrigger reception.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b1;
        end else if (w_bad_stop) begin
            r_armed <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_tick && r_rx_sync) begin
            r_armed <= 1'b1;
        end
    end

    // Idle counter next value: counts high-line ticks in IDLE, saturating.
    always_comb begin
        w_idle_nxt = r_idle_cnt;
        if ((r_state != ST_IDLE) || !r_rx_sync) begin
            w_idle_nxt = '0;
        end else if (w_tick && (r_idle_cnt != IDLE_MAX)) begin
            w_idle_nxt = r_idle_cnt + IW'(1);
        end else begin
            w_idle_nxt = r_idle_cnt;
        end
    end

    // Idle counter and end-of-packet pending flag.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_nxt;
            if (w_good_stop || w_bad_stop) begin
                r_pending <= 1'b1;
            end else if (w_eop_fire) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Registered outputs: data, status pulses and idle level.
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_idle  <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            if (w_good_stop) begin
                r_data <= r_shift;
            end
            r_ready <= w_good_stop;
            r_ferr  <= w_bad_stop;
            r_idle  <= (w_idle_nxt == IDLE_MAX);
            r_eop   <= w_eop_fire;
        end
    end

    assign RxD_data        = r_data;
    assign RxD_data_ready  = r_ready;
    assign framing_err     = r_ferr;
    assign RxD_idle        = r_idle;
    assign RxD_endofpacket = r_eop;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at BAUD_DIV=4 (64 clk_fast per bit).
module tb_uart_frame_rx;

    localparam int BIT = 64;

    logic       clk_fast = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rx       = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       framing_err;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    uart_frame_rx #(.BAUD_DIV(4), .IDLE_TICKS(160)) dut (
        .clk_fast        (clk_fast),
        .reset_n         (reset_n),
        .rx              (rx),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .framing_err     (framing_err),
        .RxD_idle        (RxD_idle),
        .RxD_endofpacket (RxD_endofpacket)
    );

    always #5 clk_fast = ~clk_fast;

    int total = 0;
    int bad   = 0;

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         n_ready = 0;
    int         n_ferr = 0;
    int         n_eop = 0;
    int         n_both = 0;
    int         eop_cyc = -1;
    int         idle_rise_cyc = -2;
    logic       prev_idle = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk_fast) begin
        cyc = cyc + 1;
        if (RxD_data_ready) begin
            n_ready = n_ready + 1;
            got_q.push_back(RxD_data);
        end
        if (framing_err) n_ferr = n_ferr + 1;
        if (RxD_data_ready && framing_err) n_both = n_both + 1;
        if (RxD_endofpacket) begin
            n_eop   = n_eop + 1;
            eop_cyc = cyc;
        end
        if (RxD_idle && !prev_idle) idle_rise_cyc = cyc;
        prev_idle = RxD_idle;
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk_fast);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic gap(input int bits);
        rx = 1'b1;
        repeat (bits * BIT) @(negedge clk_fast);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_rdy;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[6];

    initial begin
        int r0;
        int f0;
        int e0;
        int base;
        logic [7:0] bb[4];

        vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vt[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vt[2] = '{8'h3C, 1'b0, 0, 1, 8'h5A};
        vt[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vt[4] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vt[5] = '{8'hC3, 1'b0, 0, 1, 8'h80};
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h81; bb[3] = 8'h7E;

        // Reset state
        repeat (5) @(negedge clk_fast);
        chk("rst_data",  int'(RxD_data), 0);
        chk("rst_ready", int'(RxD_data_ready), 0);
        chk("rst_ferr",  int'(framing_err), 0);
        chk("rst_idle",  int'(RxD_idle), 0);
        chk("rst_eop",   int'(RxD_endofpacket), 0);
        reset_n = 1'b1;

        // Idle with no byte yet: RxD_idle rises, no end-of-packet
        repeat (700) @(negedge clk_fast);
        chk("idle_no_byte_idle", int'(RxD_idle), 1);
        chk("idle_no_byte_eop",  n_eop, 0);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            r0 = n_ready;
            f0 = n_ferr;
            send_frame(vt[i].d, vt[i].stop);
            gap(2);
            chk($sformatf("vec%0d_data", i),  int'(RxD_data), int'(vt[i].exp_data));
            chk($sformatf("vec%0d_ready", i), n_ready - r0, vt[i].exp_rdy);
            chk($sformatf("vec%0d_ferr", i),  n_ferr - f0, vt[i].exp_ferr);
        end

        // Start glitch of 4 ticks is rejected
        r0 = n_ready;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (16) @(negedge clk_fast);
        gap(3);
        chk("glitch_ready", n_ready - r0, 0);
        chk("glitch_ferr",  n_ferr - f0, 0);
        chk("glitch_data",  int'(RxD_data), 8'h80);
        send_frame(8'h96, 1'b1);
        gap(2);
        chk("after_glitch_data",  int'(RxD_data), 8'h96);
        chk("after_glitch_ready", n_ready - r0, 1);

        // Framing error followed by a 30-bit break
        r0 = n_ready;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 30; i++) send_bit(1'b0);
        chk("break_ferr",  n_ferr - f0, 1);
        chk("break_ready", n_ready - r0, 0);
        chk("break_data",  int'(RxD_data), 8'h96);
        gap(2);
        chk("break_release_ferr", n_ferr - f0, 1);
        send_frame(8'h4B, 1'b1);
        gap(2);
        chk("after_break_data",  int'(RxD_data), 8'h4B);
        chk("after_break_ready", n_ready - r0, 1);

        // Back-to-back frames, then idle / end-of-packet
        r0   = n_ready;
        e0   = n_eop;
        base = got_q.size();
        for (int i = 0; i < 4; i++) send_frame(bb[i], 1'b1);
        rx = 1'b1;
        repeat (550) @(negedge clk_fast);
        chk("b2b_count", n_ready - r0, 4);
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > base + i) begin
                chk($sformatf("b2b_byte%0d", i), int'(got_q[base + i]), int'(bb[i]));
            end else begin
                chk($sformatf("b2b_byte%0d_missing", i), got_q.size(), base + i + 1);
            end
        end
        chk("early_idle", int'(RxD_idle), 0);
        chk("early_eop",  n_eop - e0, 0);
        repeat (150) @(negedge clk_fast);
        chk("idle_level",      int'(RxD_idle), 1);
        chk("eop_count",       n_eop - e0, 1);
        chk("eop_with_idle",   eop_cyc, idle_rise_cyc);
        repeat (1500) @(negedge clk_fast);
        chk("eop_no_repeat",   n_eop - e0, 1);
        chk("idle_held",       int'(RxD_idle), 1);

        // Reset during data bit 4 of 0x55 aborts the frame
        r0 = n_ready;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 8'h00);
        rx = 1'b1;
        repeat (20) @(negedge clk_fast);
        reset_n = 1'b0;
        repeat (4) @(negedge clk_fast);
        chk("midrst_data_in_reset", int'(RxD_data), 0);
        reset_n = 1'b1;
        gap(3);
        chk("midrst_ready", n_ready - r0, 0);
        chk("midrst_ferr",  n_ferr - f0, 0);
        send_frame(8'h12, 1'b1);
        gap(2);
        chk("after_rst_data",  int'(RxD_data), 8'h12);
        chk("after_rst_ready", n_ready - r0, 1);

        chk("ready_ferr_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter BAUD_DIV, default 27, SHALL set the clk_fast cycles per 16x oversample tick (50 MHz / (115200*16)).
REQ-002 Parameter IDLE_TICKS, default 160, SHALL set the ticks of continuous high line that define idle (10 bit times).
REQ-003 Port clk_fast  input  1: single clock for all logic; rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port rx  input  1: asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 Port RxD_data  output  8: last correctly framed byte; held until the next good byte.
REQ-007 Port RxD_data_ready  output  1: one-cycle pulse, RxD_data newly valid (feeds mode_setter byte counting).
REQ-008 Port framing_err  output  1: one-cycle pulse, stop bit sampled low.
REQ-009 Port RxD_idle  output  1: level, line high for at least IDLE_TICKS ticks while in IDLE.
REQ-010 Port RxD_endofpacket  output  1: one-cycle pulse when RxD_idle rises after at least one byte (good or errored).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-012 Free-running tick counter 0..BAUD_DIV-1 SHALL pulse tick for one cycle on wrap; it is never re-phased by rx.
REQ-013 States SHALL be IDLE, START, DATA, STOP; per-bit sample counter 0..15 advances on each tick.
REQ-014 IDLE: on a tick with synchronized rx low and armed=1, go to START, sample counter 0.
REQ-015 Each bit value SHALL be the majority of the samples at counts 7, 8, 9, resolved at count 9.
REQ-016 START: majority high at count 9 -> IDLE (glitch reject, no output); majority low -> DATA at count 15 wrap, bit index 0.
REQ-017 DATA: resolved bit shifts into bit [7] of the shift register (LSB first); after bit index 7 completes count 15 -> STOP.
REQ-018 STOP: at count 9, majority high -> RxD_data <= shift register and RxD_data_ready pulses the next cycle; majority low -> framing_err pulses, RxD_data unchanged, armed <= 0.
REQ-019 STOP SHALL return to IDLE at count 9, not count 15, so a start edge in the second half of the stop bit is caught.
REQ-020 armed SHALL be set by any tick in IDLE with rx high; a line held low after a framing error (break) SHALL NOT retrigger START.
REQ-021 Idle counter SHALL count ticks in IDLE with rx high, saturate at IDLE_TICKS, and clear on rx low or on leaving IDLE.
REQ-022 RxD_idle SHALL be 1 exactly when the idle counter equals IDLE_TICKS.
REQ-023 pending_eop SHALL set on any STOP resolution and clear when RxD_endofpacket fires; RxD_endofpacket fires the cycle the idle counter reaches IDLE_TICKS with pending_eop=1.
REQ-024 RxD_data_ready and framing_err SHALL never assert in the same cycle; a maximum of one pulse per frame.
REQ-025 Throughput: back-to-back frames with no gap between stop and next start SHALL all be received.

Reset
REQ-026 On reset_n low, asynchronously: synchronizer flops=1, state=IDLE, counters=0, shift register=0, RxD_data=0x00, armed=1, pending_eop=0, all pulse outputs=0, RxD_idle=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse output; reception after release restarts on the next start edge.

Verification (BAUD_DIV=4, 64 clk_fast per bit)
REQ-028 Frame 0xA5 with a valid stop -> RxD_data=0xA5, exactly one RxD_data_ready pulse, 1 cycle after stop count 9; no framing_err.
REQ-029 rx low for 4 ticks then high -> state returns to IDLE, no outputs pulse, RxD_data unchanged.
REQ-030 Frame 0x3C with stop bit 0, line then held low 30 bit times, then high -> one framing_err, RxD_data keeps the prior value, no START until the line is high.
REQ-031 Frames 0x00, 0xFF, 0x81, 0x7E sent back-to-back with zero gap -> four ready pulses in order with matching data.
REQ-032 Four bytes then idle line -> RxD_idle rises 160 ticks after the last stop entry to IDLE, with one RxD_endofpacket pulse in the same cycle; continued idle -> no further endofpacket pulses.
REQ-033 reset_n pulsed low during DATA bit 4 of 0x55 -> no ready pulse; the following frame 0x12 is received correctly.
